// File: rtl/ftdi_async_sync.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_async_sync
// Description : Pin-level front end for an FT245-style asynchronous FIFO.
//               Synchronises RXF#/TXE#, times the RD#/WR# strobes, samples
//               and drives the 8-bit data bus, and presents one rx byte
//               stream and one tx byte stream with valid/accept handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_async_sync #(
    parameter int RD_PULSE_CYCLES = 4,
    parameter int WR_PULSE_CYCLES = 4,
    parameter int RECOVERY_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ftdi_rxf_i,
    input  logic       ftdi_txe_i,
    output logic       ftdi_rd_o,
    output logic       ftdi_wr_o,
    input  logic [7:0] ftdi_data_i,
    output logic [7:0] ftdi_data_o,
    output logic       ftdi_data_oe_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_accept_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_accept_o
);

    // Shared phase counter; all cycle parameters must fit in 8 bits.
    localparam int             c_CNT_W   = 8;
    localparam logic [c_CNT_W-1:0] c_RD_LAST  = c_CNT_W'(RD_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST  = c_CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REC_LAST = c_CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;

    logic r_rxf_meta, r_rxf_sync;
    logic r_txe_meta, r_txe_sync;

    logic r_rd_seen, r_wr_seen, r_last_wr;

    logic       r_tx_full;
    logic [7:0] r_tx_buf;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;

    logic       r_rd_n, r_wr_n, r_oe;
    logic [7:0] r_data_out;

    logic w_rx_space, w_rx_take;
    logic w_rd_req, w_wr_req, w_rd_go, w_wr_go;
    logic w_rd_done, w_wr_done, w_tx_load;

    // Requests are evaluated only from synchronised flags. A request must be
    // seen on two consecutive idle cycles before it is acted on, which also
    // gives both flags an equal chance to qualify before arbitration.
    assign w_rx_take  = r_rx_valid & rx_accept_i;
    assign w_rx_space = ~r_rx_valid | rx_accept_i;
    assign w_rd_req   = ~r_rxf_sync & w_rx_space;
    assign w_wr_req   = ~r_txe_sync & r_tx_full;
    assign w_rd_go    = w_rd_req & r_rd_seen;
    assign w_wr_go    = w_wr_req & r_wr_seen;
    assign w_tx_load  = tx_valid_i & ~r_tx_full;

    // Two-flop synchronisers for the asynchronous FIFO status flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rxf_meta <= 1'b1;
            r_rxf_sync <= 1'b1;
            r_txe_meta <= 1'b1;
            r_txe_sync <= 1'b1;
        end else begin
            r_rxf_meta <= ftdi_rxf_i;
            r_rxf_sync <= r_rxf_meta;
            r_txe_meta <= ftdi_txe_i;
            r_txe_sync <= r_txe_meta;
        end
    end

    // Next-state and phase-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rd_done    = 1'b0;
        w_wr_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (w_rd_go && w_wr_go) begin
                    w_state_next = r_last_wr ? ST_RD : ST_WR_SETUP;
                end else if (w_rd_go) begin
                    w_state_next = ST_RD;
                end else if (w_wr_go) begin
                    w_state_next = ST_WR_SETUP;
                end
            end
            ST_RD: begin
                if (r_cnt == c_RD_LAST) begin
                    w_state_next = ST_RECOVER;
                    w_cnt_next   = '0;
                    w_rd_done    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WR_SETUP: begin
                w_state_next = ST_WR;
                w_cnt_next   = '0;
            end
            ST_WR: begin
                if (r_cnt == c_WR_LAST) begin
                    w_state_next = ST_WR_HOLD;
                    w_cnt_next   = '0;
                    w_wr_done    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WR_HOLD: begin
                w_state_next = ST_RECOVER;
                w_cnt_next   = '0;
            end
            ST_RECOVER: begin
                if (r_cnt == c_REC_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State register, phase counter and arbitration bookkeeping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
            r_last_wr <= 1'b1;  // makes the first contested grant go to RD
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rd_seen <= (r_state == ST_IDLE) & w_rd_req;
            r_wr_seen <= (r_state == ST_IDLE) & w_wr_req;
            if (r_state == ST_IDLE && w_state_next == ST_RD) begin
                r_last_wr <= 1'b0;
            end else if (r_state == ST_IDLE && w_state_next == ST_WR_SETUP) begin
                r_last_wr <= 1'b1;
            end
        end
    end

    // Pin outputs registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_oe       <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            r_rd_n <= (w_state_next != ST_RD);
            r_wr_n <= (w_state_next != ST_WR);
            r_oe   <= (w_state_next == ST_WR_SETUP) ||
                      (w_state_next == ST_WR) ||
                      (w_state_next == ST_WR_HOLD);
            if (r_state == ST_IDLE && w_state_next == ST_WR_SETUP) begin
                r_data_out <= r_tx_buf;
            end
        end
    end

    // Single-entry tx holding register; freed as WR# rises.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tx_full <= 1'b0;
            r_tx_buf  <= 8'h00;
        end else if (w_wr_done) begin
            r_tx_full <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_full <= 1'b1;
            r_tx_buf  <= tx_data_i;
        end
    end

    // Single-entry rx buffer; filled on the last RD# clock, freed on handshake.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else if (w_rd_done) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= ftdi_data_i;
        end else if (w_rx_take) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign ftdi_rd_o      = r_rd_n;
    assign ftdi_wr_o      = r_wr_n;
    assign ftdi_data_o    = r_data_out;
    assign ftdi_data_oe_o = r_oe;
    assign rx_valid_o     = r_rx_valid;
    assign rx_data_o      = r_rx_data;
    assign tx_accept_o    = ~r_tx_full;

endmodule
`default_nettype wire
